// File: rtl/spi_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : spi_sequencer
// Summary  : Byte buffer that streams up to BUF_DEPTH bytes through an SPI byte
//            master, overwriting each sent byte with the byte received for it.
// Revision : 1.0
// =============================================================================
module spi_sequencer #(
    parameter int BUF_DEPTH = 32,
    parameter int AW        = $clog2(BUF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    input  logic          host_we,
    output logic [7:0]    host_rdata,
    input  logic          start,
    input  logic [AW:0]   xfer_len,
    output logic          busy,
    output logic          done,
    output logic          cs_active,
    output logic          xfer_start,
    output logic [7:0]    tx_data,
    input  logic          xfer_complete,
    input  logic [7:0]    rx_data
);

    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(BUF_DEPTH);

    typedef enum logic [5:0] {
        IDLE  = 6'b000001,
        FETCH = 6'b000010,
        LOAD  = 6'b000100,
        WAIT  = 6'b001000,
        ADV   = 6'b010000,
        FIN   = 6'b100000
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          xfer_start_q, xfer_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    host_rdata_q, host_rdata_d;
    logic [7:0]    seq_rdata_q, seq_rdata_d;
    logic          seq_we;

    logic [7:0]    mem_q [BUF_DEPTH];

    // The two write sources never overlap: the sequencer only writes while busy.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            mem_q[idx_q] <= rx_data;
        end else if (host_we && !busy_q) begin
            mem_q[host_addr] <= host_wdata;
        end
        seq_rdata_q <= seq_rdata_d;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        xfer_start_d = 1'b0;
        tx_data_d    = tx_data_q;
        seq_we       = 1'b0;
        host_rdata_d = mem_q[host_addr];
        seq_rdata_d  = mem_q[idx_q];

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = (xfer_len > DEPTH_LEN) ? DEPTH_LEN : xfer_len;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (xfer_len == '0) ? FIN : FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                tx_data_d    = seq_rdata_q;
                xfer_start_d = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                // A completion coinciding with reset must not touch the buffer.
                if (xfer_complete && !rst) begin
                    seq_we  = 1'b1;
                    state_d = ADV;
                end
            end
            ADV: begin
                idx_d   = idx_q + AW'(1);
                state_d = (({1'b0, idx_q} + (AW+1)'(1)) == len_q) ? FIN : FETCH;
            end
            FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            xfer_start_q <= 1'b0;
            tx_data_q    <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            xfer_start_q <= xfer_start_d;
            tx_data_q    <= tx_data_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign host_rdata = host_rdata_q;
    assign busy       = busy_q;
    assign cs_active  = busy_q;
    assign done       = done_q;
    assign xfer_start = xfer_start_q;
    assign tx_data    = tx_data_q;

endmodule
`default_nettype wire
